// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3 memory arbiter: FSM states, requester ids
// and the registered downstream request bundle.
package arb_types;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 16;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IBUSY,
        ARB_DBUSY
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ARB_BE_W-1:0]   byte_enable;
        logic [ARB_ADDR_W-1:0] address;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    // Write wins when a requester raises read and write together.
    function automatic mem_req_t make_req(
        input logic                  rd,
        input logic                  wr,
        input logic [ARB_BE_W-1:0]   be,
        input logic [ARB_ADDR_W-1:0] addr,
        input logic [ARB_DATA_W-1:0] wdata
    );
        mem_req_t r;
        r.read        = rd & ~wr;
        r.write       = wr;
        r.byte_enable = be;
        r.address     = addr;
        r.wdata       = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_req_reg.sv
// Request register feeding the downstream memory port.
// Ports: clk, reset (async high), i_load, i_clear, i_req -> o_req.
module arb_req_reg
    import arb_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_load,
    input  logic     i_clear,
    input  mem_req_t i_req,
    output mem_req_t o_req
);

    mem_req_t r_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
        end else if (i_clear) begin
            r_req <= '0;
        end else if (i_load) begin
            r_req <= i_req;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction- and data-side requests onto one memory port.
// Ports: clk, reset, i_* / d_* requester sides, mem_* downstream port.
module mem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [BE_W-1:0]   i_byte_enable,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [BE_W-1:0]   d_byte_enable,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byte_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    requester_t r_last_grant;
    requester_t w_next_last;
    requester_t w_sel;
    logic       w_load;
    logic       w_clear;
    logic       w_i_pend;
    logic       w_d_pend;
    mem_req_t   w_req_in;
    mem_req_t   w_req_q;

    assign w_i_pend = i_read | i_write;
    assign w_d_pend = d_read | d_write;

    assign w_req_in = (w_sel == REQ_D)
        ? make_req(d_read, d_write, d_byte_enable, d_address, d_wdata)
        : make_req(i_read, i_write, i_byte_enable, i_address, i_wdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= REQ_I;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last_grant;
        w_sel        = REQ_I;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                // D has priority, except right after a D access so I
                // can never be starved by a busy data side.
                if (w_d_pend && (!w_i_pend || r_last_grant == REQ_I)) begin
                    w_sel        = REQ_D;
                    w_load       = 1'b1;
                    w_next_state = ARB_DBUSY;
                end else if (w_i_pend) begin
                    w_sel        = REQ_I;
                    w_load       = 1'b1;
                    w_next_state = ARB_IBUSY;
                end
            end
            ARB_IBUSY: begin
                if (mem_resp) begin
                    i_resp       = 1'b1;
                    w_clear      = 1'b1;
                    w_next_last  = REQ_I;
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_DBUSY: begin
                if (mem_resp) begin
                    d_resp       = 1'b1;
                    w_clear      = 1'b1;
                    w_next_last  = REQ_D;
                    w_next_state = ARB_IDLE;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // Read data reaches only the owner, and only in its completion cycle.
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

    arb_req_reg u_req_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_req   (w_req_in),
        .o_req   (w_req_q)
    );

    assign mem_read        = w_req_q.read;
    assign mem_write       = w_req_q.write;
    assign mem_byte_enable = w_req_q.byte_enable;
    assign mem_address     = w_req_q.address;
    assign mem_wdata       = w_req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized two-sided traffic against a
// transaction-level arbitration model, plus directed corner cases.
module tb_mem_arbiter;
    import arb_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read, i_write, d_read, d_write;
    logic [1:0]  i_byte_enable, d_byte_enable;
    logic [15:0] i_address, d_address, i_wdata, d_wdata;
    logic        i_resp, d_resp;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .i_read          (i_read),
        .i_write         (i_write),
        .i_byte_enable   (i_byte_enable),
        .i_address       (i_address),
        .i_wdata         (i_wdata),
        .i_resp          (i_resp),
        .i_rdata         (i_rdata),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_byte_enable   (d_byte_enable),
        .d_address       (d_address),
        .d_wdata         (d_wdata),
        .d_resp          (d_resp),
        .d_rdata         (d_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
    } item_t;

    item_t q_i[$];
    item_t q_d[$];
    int    checks = 0;
    int    errors = 0;
    bit    model_en = 1'b0;
    bit    mem_auto = 1'b0;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit side, input item_t it);
        if (side) begin
            d_read = it.rd; d_write = it.wr; d_byte_enable = it.be;
            d_address = it.addr; d_wdata = it.wdata;
        end else begin
            i_read = it.rd; i_write = it.wr; i_byte_enable = it.be;
            i_address = it.addr; i_wdata = it.wdata;
        end
    endtask

    task automatic clear_req(input bit side);
        item_t z;
        z = '{rd: 1'b0, wr: 1'b0, be: 2'b00, addr: 16'h0, wdata: 16'h0};
        set_req(side, z);
    endtask

    function automatic logic side_resp(input bit side);
        return side ? d_resp : i_resp;
    endfunction

    // Requester: issue, hold until its response, then drop or re-issue.
    task automatic run_side(input bit side, input int n, input int max_gap);
        item_t it;
        int    op;
        int    budget;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk); #1;
            end
            op = $urandom_range(0, 2);
            it.rd = (op != 1);
            it.wr = (op != 0);
            it.be = 2'($urandom_range(1, 3));
            it.addr = 16'($urandom);
            it.wdata = 16'($urandom);
            if (side) q_d.push_back(it);
            else q_i.push_back(it);
            set_req(side, it);
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!side_resp(side) && budget < 60);
            chk(side ? "d_resp_arrives" : "i_resp_arrives",
                side_resp(side), 1);
            @(posedge clk); #1;
            clear_req(side);
        end
    endtask

    // Memory: random wait states, ROM-like read data, stray mem_resp in idle.
    initial begin
        bit active;
        int wait_left;
        active = 1'b0;
        wait_left = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_auto) begin
                if (reset) begin
                    active = 1'b0;
                    mem_resp = 1'b0;
                end else if (mem_read || mem_write) begin
                    if (!active) begin
                        active = 1'b1;
                        wait_left = $urandom_range(0, 3);
                    end
                    if (wait_left == 0) begin
                        mem_resp = 1'b1;
                        mem_rdata = mem_read ? rom(mem_address)
                                             : 16'($urandom);
                        active = 1'b0;
                    end else begin
                        mem_resp = 1'b0;
                        mem_rdata = 16'($urandom);
                        wait_left--;
                    end
                end else begin
                    mem_resp = ($urandom_range(0, 7) == 0);
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // Scoreboard monitor: transaction-level model of who owns the port.
    initial begin
        bit    m_busy;
        bit    m_owner;
        bit    m_last;
        bit    ip, dp;
        item_t cur;
        m_busy = 1'b0;
        m_last = 1'b0;
        cur = '{rd: 1'b0, wr: 1'b0, be: 2'b00, addr: 16'h0, wdata: 16'h0};
        forever begin
            @(negedge clk);
            if (model_en) begin
                if (!m_busy) begin
                    chk("idle_mem_read", mem_read, 0);
                    chk("idle_mem_write", mem_write, 0);
                    chk("idle_i_resp", i_resp, 0);
                    chk("idle_d_resp", d_resp, 0);
                    ip = i_read | i_write;
                    dp = d_read | d_write;
                    if (ip || dp) begin
                        // 1 = data side; with both pending, serve the
                        // side that was not served last.
                        m_owner = (ip && dp) ? ~m_last : dp;
                        if (m_owner) begin
                            chk("d_queue_has_item", q_d.size() != 0, 1);
                            if (q_d.size() != 0) cur = q_d.pop_front();
                        end else begin
                            chk("i_queue_has_item", q_i.size() != 0, 1);
                            if (q_i.size() != 0) cur = q_i.pop_front();
                        end
                        m_busy = 1'b1;
                    end
                end else begin
                    chk("busy_mem_read", mem_read, cur.rd & ~cur.wr);
                    chk("busy_mem_write", mem_write, cur.wr);
                    chk("busy_mem_be", mem_byte_enable, cur.be);
                    chk("busy_mem_addr", mem_address, cur.addr);
                    chk("busy_mem_wdata", mem_wdata, cur.wdata);
                    if (mem_resp) begin
                        chk("owner_resp", m_owner ? d_resp : i_resp, 1);
                        chk("other_resp", m_owner ? i_resp : d_resp, 0);
                        chk("owner_rdata", m_owner ? d_rdata : i_rdata,
                            cur.wr ? mem_rdata : rom(cur.addr));
                        chk("other_rdata", m_owner ? i_rdata : d_rdata, 0);
                        m_last = m_owner;
                        m_busy = 1'b0;
                    end else begin
                        chk("wait_i_resp", i_resp, 0);
                        chk("wait_d_resp", d_resp, 0);
                        chk("wait_i_rdata", i_rdata, 0);
                        chk("wait_d_rdata", d_rdata, 0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        reset = 1'b1;
        mem_resp = 1'b0;
        mem_rdata = 16'h0;
        clear_req(0);
        clear_req(1);

        @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_be", mem_byte_enable, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        @(posedge clk); #1;
        reset = 1'b0;
        mem_auto = 1'b1;
        model_en = 1'b1;

        // Back-to-back from both sides: must alternate D, I, D, I ...
        fork
            run_side(0, 4, 0);
            run_side(1, 4, 0);
        join
        // Random gaps, ops and wait states.
        fork
            run_side(0, 40, 3);
            run_side(1, 40, 3);
        join
        repeat (3) begin
            @(posedge clk); #1;
        end
        model_en = 1'b0;
        mem_auto = 1'b0;
        mem_resp = 1'b0;
        chk("queues_drained", q_i.size() + q_d.size(), 0);

        // I read, zero-wait memory.
        i_read = 1'b1; i_address = 16'h0040; i_byte_enable = 2'b11;
        @(negedge clk);
        chk("t1_c0_mem_read", mem_read, 0);
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk);
        chk("t1_mem_read", mem_read, 1);
        chk("t1_mem_addr", mem_address, 16'h0040);
        chk("t1_i_resp", i_resp, 1);
        chk("t1_i_rdata", i_rdata, 16'h1234);
        chk("t1_d_resp", d_resp, 0);
        chk("t1_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        clear_req(0); mem_resp = 1'b0;
        @(negedge clk);
        chk("t1_after_mem_read", mem_read, 0);

        // Read and write together: write wins.
        it = '{rd: 1'b1, wr: 1'b1, be: 2'b11, addr: 16'h0002,
               wdata: 16'hA5A5};
        set_req(0, it);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_mem_write", mem_write, 1);
        chk("t6_mem_read", mem_read, 0);
        chk("t6_mem_wdata", mem_wdata, 16'hA5A5);
        chk("t6_mem_addr", mem_address, 16'h0002);
        @(posedge clk); #1;
        mem_resp = 1'b1;
        @(negedge clk);
        chk("t6_i_resp", i_resp, 1);
        @(posedge clk); #1;
        clear_req(0); mem_resp = 1'b0;

        // D read with 3 wait cycles, address toggled while waiting.
        it = '{rd: 1'b1, wr: 1'b0, be: 2'b10, addr: 16'h0300,
               wdata: 16'h0};
        set_req(1, it);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            d_address = 16'($urandom);
            mem_resp = (c == 4);
            mem_rdata = 16'hBEAD;
            @(negedge clk);
            chk("t4_mem_read", mem_read, 1);
            chk("t4_mem_addr", mem_address, 16'h0300);
            chk("t4_d_resp", d_resp, (c == 4));
        end
        chk("t4_d_rdata", d_rdata, 16'hBEAD);
        @(posedge clk); #1;
        clear_req(1); mem_resp = 1'b0;

        // Reset aborts an in-flight I read.
        i_read = 1'b1; i_address = 16'h0050;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_granted", mem_read, 1);
        #1;
        reset = 1'b1; mem_resp = 1'b1; mem_rdata = 16'h1111;
        #1;
        chk("t5_abort_mem_read", mem_read, 0);
        chk("t5_abort_i_resp", i_resp, 0);
        @(posedge clk); #1;
        reset = 1'b0; clear_req(0);
        @(negedge clk);
        chk("t5_stray_i_resp", i_resp, 0);
        chk("t5_stray_d_resp", d_resp, 0);
        chk("t5_stray_mem_read", mem_read, 0);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        i_read = 1'b1; i_address = 16'h0050;
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 16'h7777;
        @(negedge clk);
        chk("t5_retry_mem_read", mem_read, 1);
        chk("t5_retry_i_resp", i_resp, 1);
        chk("t5_retry_i_rdata", i_rdata, 16'h7777);
        @(posedge clk); #1;
        clear_req(0); mem_resp = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
